// File: rtl/frame_writer_pkg.sv
// Shared constants and state encoding for the frame-buffer writer and its neighbours.
package frame_writer_pkg;

  localparam int unsigned DEF_WORDS_PER_FRAME = 2048;
  localparam int unsigned DEF_N_FRAMES        = 15;
  localparam int unsigned ADDR_W              = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/frame_writer_pixel_packer.sv
// Collects three bytes MSB first into one 24-bit {R,G,B} pixel word.
module pixel_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [23:0] word,
  output logic        word_done
);

  logic [1:0] phase_q;
  logic [7:0] r_q;
  logic [7:0] g_q;

  // The third byte completes the word combinationally so the writer can register it directly.
  assign word      = {r_q, g_q, byte_in};
  assign word_done = byte_en && (phase_q == 2'd2);

  // Byte phase and the two buffered colour bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      r_q     <= '0;
      g_q     <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (byte_en) begin
      case (phase_q)
        2'd0: begin
          r_q     <= byte_in;
          phase_q <= 2'd1;
        end
        2'd1: begin
          g_q     <= byte_in;
          phase_q <= 2'd2;
        end
        default: phase_q <= '0;
      endcase
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Parses a SYNC / frame-number / RGB byte stream and writes pixel words into the frame buffer.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
  parameter int unsigned N_FRAMES        = DEF_N_FRAMES,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int unsigned PIX_W   = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int unsigned FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state_q;
  state_t             state_d;
  logic [PIX_W-1:0]   pixel_q;
  logic [FRAME_W-1:0] frame_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [ADDR_W-1:0]  addr;
  logic [23:0]        word;
  logic               word_done;
  logic               hs;
  logic               to_hit;
  logic               counting;
  logic               bad_frame;
  logic               timeout;

  assign hs       = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign counting = (state_q == HDR) || (state_q == DATA);
  assign to_hit   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  // Computed at full output width; the largest frame/pixel pair still fits without wrap.
  assign addr     = ADDR_W'(frame_q) * ADDR_W'(WORDS_PER_FRAME) + ADDR_W'(pixel_q);

  pixel_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_q != DATA),
    .byte_en   (hs && (state_q == DATA)),
    .byte_in   (in_data),
    .word      (word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the error and timeout conditions.
  always_comb begin
    state_d   = state_q;
    bad_frame = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs && (in_data == SYNC_BYTE)) state_d = HDR;
      end
      HDR: begin
        if (hs) begin
          if (32'(in_data) < N_FRAMES) begin
            state_d = DATA;
          end else begin
            bad_frame = 1'b1;
            state_d   = IDLE;
          end
        end else if (to_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (word_done && (pixel_q == PIX_W'(WORDS_PER_FRAME - 1))) begin
          state_d = DONE;
        end else if (!hs && to_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, frame/pixel tracking and the idle-clock timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      pixel_q    <= '0;
      frame_q    <= '0;
      to_cnt_q   <= '0;
    end else begin
      in_ready   <= (state_d != DONE);
      wr_en      <= word_done;
      frame_done <= (state_d == DONE);
      err        <= bad_frame || timeout;
      if (state_q == HDR) begin
        pixel_q <= '0;
        if (hs) frame_q <= in_data[FRAME_W-1:0];
      end
      if (word_done) begin
        wr_addr <= addr;
        wr_data <= word;
        pixel_q <= pixel_q + PIX_W'(1);
      end
      if (counting && !hs && (state_d == state_q)) to_cnt_q <= to_cnt_q + TO_W'(1);
      else                                         to_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer with a byte-level stream model checked every cycle.
module tb_frame_writer;

  localparam int          WPF  = 2048;
  localparam int          NF   = 15;
  localparam int          TMO  = 100;
  localparam logic [7:0]  SYNC = 8'hA5;

  localparam int M_HUNT = 0;
  localparam int M_HDR  = 1;
  localparam int M_PAY  = 2;
  localparam int M_END  = 3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [14:0] wr_a[$];
  logic [23:0] wr_d[$];
  int          n_err  = 0;
  int          n_done = 0;

  frame_writer #(
    .WORDS_PER_FRAME (WPF),
    .N_FRAMES        (NF),
    .SYNC_BYTE       (SYNC),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Stream model: consumes accepted bytes and predicts every output for the next cycle.
  initial begin : model
    int          m_mode;
    int          m_frame;
    int          m_pix;
    int          m_nb;
    int          m_idle;
    int unsigned m_acc;
    logic        hs;
    logic        e_ready, e_wr, e_done, e_err, e_busy;
    logic [14:0] e_addr;
    logic [23:0] e_data;
    m_mode = M_HUNT; m_frame = 0; m_pix = 0; m_nb = 0; m_idle = 0; m_acc = 0;
    e_ready = 0; e_wr = 0; e_done = 0; e_err = 0; e_busy = 0; e_addr = 0; e_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_err", 32'(err), 0);
        m_mode = M_HUNT; m_nb = 0; m_acc = 0; m_idle = 0;
        e_ready = 0; e_wr = 0; e_done = 0; e_err = 0; e_busy = 0;
        continue;
      end
      if (wr_en) begin
        wr_a.push_back(wr_addr);
        wr_d.push_back(wr_data);
      end
      n_err  += int'(err);
      n_done += int'(frame_done);
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("wr_en", 32'(wr_en), 32'(e_wr));
      if (e_wr) begin
        chk("wr_addr", 32'(wr_addr), 32'(e_addr));
        chk("wr_data", 32'(wr_data), 32'(e_data));
      end
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("busy", 32'(busy), 32'(e_busy));

      hs = in_valid && e_ready;
      e_wr = 0; e_done = 0; e_err = 0;
      case (m_mode)
        M_HUNT: if (hs && in_data == SYNC) begin m_mode = M_HDR; m_idle = 0; end
        M_HDR: begin
          if (hs) begin
            if (int'(in_data) < NF) begin
              m_mode = M_PAY; m_frame = int'(in_data);
              m_pix = 0; m_nb = 0; m_acc = 0; m_idle = 0;
            end else begin
              e_err = 1; m_mode = M_HUNT;
            end
          end else begin
            m_idle++;
            if (m_idle == TMO) begin e_err = 1; m_mode = M_HUNT; end
          end
        end
        M_PAY: begin
          if (hs) begin
            m_idle = 0;
            m_acc  = (m_acc << 8) | 32'(in_data);
            m_nb++;
            if (m_nb == 3) begin
              e_wr   = 1;
              e_addr = 15'(m_frame * WPF + m_pix);
              e_data = m_acc[23:0];
              m_pix++; m_nb = 0; m_acc = 0;
              if (m_pix == WPF) begin e_done = 1; m_mode = M_END; end
            end
          end else begin
            m_idle++;
            if (m_idle == TMO) begin e_err = 1; m_mode = M_HUNT; end
          end
        end
        default: m_mode = M_HUNT;
      endcase
      e_ready = (m_mode != M_END);
      e_busy  = (m_mode != M_HUNT);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic ok;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected handshake within 1000 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int base;
    int e0;
    int d0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_wr_addr", 32'(wr_addr), 0);
    rst_n = 1'b1;
    idle(1);
    chk("ready_after_release", 32'(in_ready), 1);

    // Junk before sync, then a single pixel into frame 0; the open frame then times out.
    base = wr_a.size(); e0 = n_err;
    send_byte(8'h00); send_byte(8'h13); send_byte(SYNC); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(3);
    chk("t2_nwr", 32'(wr_a.size() - base), 1);
    if (wr_a.size() > base) begin
      chk("t2_addr", 32'(wr_a[base]), 0);
      chk("t2_data", 32'(wr_d[base]), 32'h112233);
    end
    idle(110);
    chk("t2_timeout_err", 32'(n_err - e0), 1);
    chk("t2_idle_busy", 32'(busy), 0);

    // Out-of-range frame number.
    base = wr_a.size(); e0 = n_err;
    send_byte(SYNC); send_byte(8'h0F);
    chk("t3_err_pulse", 32'(err), 1);
    chk("t3_busy_low", 32'(busy), 0);
    idle(3);
    chk("t3_nwr", 32'(wr_a.size() - base), 0);
    chk("t3_nerr", 32'(n_err - e0), 1);

    // Full frame 2 at one byte per cycle.
    base = wr_a.size(); e0 = n_err; d0 = n_done;
    send_byte(SYNC); send_byte(8'h02);
    for (int i = 0; i < 3 * WPF; i++) send_byte(8'((i * 7 + 3) & 255));
    idle(4);
    chk("t4_nwr", 32'(wr_a.size() - base), 2048);
    if (wr_a.size() > base) begin
      chk("t4_first_addr", 32'(wr_a[base]), 4096);
      chk("t4_first_data", 32'(wr_d[base]), 32'h030A11);
      chk("t4_last_addr", 32'(wr_a[$]), 6143);
      chk("t4_last_data", 32'(wr_d[$]), 32'hEEF5FC);
    end
    chk("t4_ndone", 32'(n_done - d0), 1);
    chk("t4_nerr", 32'(n_err - e0), 0);

    // Partial frame 1 followed by silence.
    base = wr_a.size(); e0 = n_err;
    send_byte(SYNC); send_byte(8'h01);
    for (int i = 0; i < 3000; i++) send_byte(8'(i & 255));
    idle(120);
    chk("t5_nwr", 32'(wr_a.size() - base), 1000);
    if (wr_a.size() > base) begin
      chk("t5_last_addr", 32'(wr_a[$]), 3047);
      chk("t5_last_data", 32'(wr_d[$]), 32'hB5B6B7);
    end
    chk("t5_nerr", 32'(n_err - e0), 1);
    chk("t5_busy", 32'(busy), 0);

    // Reset in the middle of frame 3, then a fresh pixel into frame 0.
    e0 = n_err;
    send_byte(SYNC); send_byte(8'h03);
    for (int i = 0; i < 500; i++) send_byte(8'((i + 64) & 255));
    rst_n = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 0);
    chk("t6_wr_en", 32'(wr_en), 0);
    chk("t6_wr_addr", 32'(wr_addr), 0);
    chk("t6_wr_data", 32'(wr_data), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err", 32'(err), 0);
    idle(2);
    rst_n = 1'b1;
    chk("t6_no_err", 32'(n_err - e0), 0);
    idle(1);
    chk("t6_ready_rise", 32'(in_ready), 1);
    base = wr_a.size();
    send_byte(SYNC); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(3);
    chk("t6_nwr", 32'(wr_a.size() - base), 1);
    if (wr_a.size() > base) begin
      chk("t6_addr", 32'(wr_a[$]), 0);
      chk("t6_data", 32'(wr_d[$]), 32'hAABBCC);
    end
    idle(110);

    // Last frame slot, payload salted with sync bytes.
    base = wr_a.size(); d0 = n_done;
    send_byte(SYNC); send_byte(8'h0E);
    for (int i = 0; i < 3 * WPF; i++) send_byte((i % 3 == 0) ? SYNC : 8'(i & 255));
    idle(4);
    chk("t7_nwr", 32'(wr_a.size() - base), 2048);
    if (wr_a.size() > base) begin
      chk("t7_first_data", 32'(wr_d[base]), 32'hA50102);
      chk("t7_last_addr", 32'(wr_a[$]), 30719);
      chk("t7_last_data", 32'(wr_d[$]), 32'hA5FEFF);
    end
    chk("t7_ndone", 32'(n_done - d0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 2048, meaning pixel words per frame (64 cols x 32 rows).
REQ-002 SHALL have parameter N_FRAMES, default 15, meaning number of frame slots in the frame buffer.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame-start marker byte.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle clocks between bytes inside a frame.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_data, input, 8 bits: incoming byte (e.g. from UART receiver).
REQ-008 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-009 SHALL have port in_ready, output, 1 bit: byte accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port wr_en, output, 1 bit: frame-buffer write strobe.
REQ-011 SHALL have port wr_addr, output, 15 bits: linear address frame*WORDS_PER_FRAME + pixel.
REQ-012 SHALL have port wr_data, output, 24 bits: pixel word {R,G,B}.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last word of a frame is written.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on bad frame number or timeout.

Function
REQ-016 SHALL implement FSM states IDLE, HDR, DATA, DONE.
REQ-017 IDLE: SHALL discard accepted bytes until one equals SYNC_BYTE, then go to HDR.
REQ-018 HDR: SHALL capture the next accepted byte as the frame number; if < N_FRAMES go to DATA with pixel counter and byte phase cleared, else pulse err and return to IDLE.
REQ-019 DATA: SHALL assemble three accepted bytes MSB first (first = R into [23:16], second = G into [15:8], third = B into [7:0]); bytes equal to SYNC_BYTE are data here.
REQ-020 SHALL assert wr_en for exactly one cycle, the cycle after the third byte's handshake, with wr_addr = frame*WORDS_PER_FRAME + pixel and wr_data the assembled word stable in that cycle.
REQ-021 SHALL compute wr_addr without truncation before the 15-bit output (frame max 14, pixel max 2047 -> max 30719).
REQ-022 SHALL increment the pixel counter after each write; after the write of pixel WORDS_PER_FRAME-1 go to DONE.
REQ-023 DONE: SHALL pulse frame_done for one cycle, hold in_ready low that cycle, then return to IDLE.
REQ-024 SHALL hold in_ready high in IDLE, HDR and DATA, and low in DONE.
REQ-025 SHALL count clocks without a handshake while in HDR or DATA; on reaching TIMEOUT_CYCLES pulse err, abandon the frame (no further writes) and return to IDLE; counter clears on every handshake.
REQ-026 Words already written by an aborted frame SHALL remain in memory; no rollback.
REQ-027 wr_en and any handshake SHALL never require more than one byte per cycle; back-to-back bytes every cycle SHALL be accepted without loss.

Reset
REQ-028 On rst_n low, asynchronously: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, frame_done 0, err 0, all counters 0.
REQ-029 Reset asserted mid-frame SHALL abort with no err pulse; in_ready SHALL rise the first cycle after release.

Structure
REQ-030 SHALL place WORDS_PER_FRAME, N_FRAMES, the address width (15) and the FSM state encoding in a shared package also used by memory and top.
REQ-031 SHALL instantiate one sub-module, pixel_packer (byte phase counter plus 24-bit assembly register); FSM, address and timeout logic remain in frame_writer.

Verification
REQ-032 Send A5, 02, then 6144 bytes every cycle -> 2048 writes, first wr_addr 4096 data per bytes, last wr_addr 6143, one frame_done pulse.
REQ-033 Send 00, 13, A5, 00, 11, 22, 33 -> first two bytes ignored; write addr 0 data 24'h112233.
REQ-034 Send A5, 0F (frame 15) -> err pulse, no wr_en, busy low the following cycle.
REQ-035 Send A5, 01, 3000 bytes, then silence (TIMEOUT_CYCLES=100 in bench) -> 1000 writes, err pulse after 100 idle clocks, IDLE.
REQ-036 Pull rst_n low after 500 bytes of a frame -> all outputs 0 immediately, no err, next A5, 00, AA, BB, CC writes addr 0 data AABBCC.
REQ-037 Send A5, 0E, data bytes containing A5 -> treated as pixel data; last wr_addr 30719.
